// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - four-digit multiplexed 7-segment scan controller (optional SEG_LEADING_ZERO_BLANK_EN)
module seg_scan_ctrl #(
   parameter int REFRESH_DIV = 100000,
   parameter int GUARD_CYC   = 16
) (
   input  logic        CLK100MHZ,
   input  logic        CPU_RESETN,
   input  logic [15:0] digit_bcd,
   input  logic [3:0]  dp_mask,
   input  logic [3:0]  brightness,
   input  logic        blank,
   output logic [3:0]  an,
   output logic [7:0]  seg,
   output logic [1:0]  digit_idx,
   output logic        frame_tick
);

   localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] GUARD_END  = PW'(GUARD_CYC);

   typedef enum logic {ST_GUARD = 1'b0, ST_DRIVE = 1'b1} state_t;

   state_t         state_q, state_d;
   logic [PW-1:0]  presc_q, presc_d;
   logic [1:0]     idx_q, idx_d;
   logic           tick_q, tick_d;
   logic [3:0]     pwm_q, pwm_d;
   logic [15:0]    sh_bcd_q, sh_bcd_d;
   logic [3:0]     sh_dp_q, sh_dp_d;
   logic           first_q, first_d;
   logic [3:0]     an_q, an_d;
   logic [7:0]     seg_q, seg_d;

   logic           slot_end;
   logic           frame_end;
   logic [3:0]     cur_nib;
   logic           cur_dp;
   logic [6:0]     glyph;
   logic           digit_dark;

   // Slot timing, PWM phase and shadow capture (shadow only changes at frame boundaries).
   always_comb begin
      slot_end  = (presc_q == PRESC_LAST);
      frame_end = slot_end && (idx_q == 2'd3);
      presc_d   = slot_end ? '0 : presc_q + 1'b1;
      idx_d     = slot_end ? idx_q + 2'd1 : idx_q;
      tick_d    = (idx_d == 2'd3) && (presc_d == PRESC_LAST);
      pwm_d     = pwm_q + 4'd1;
      first_d   = 1'b0;
      sh_bcd_d  = sh_bcd_q;
      sh_dp_d   = sh_dp_q;
      if (frame_end || first_q) begin
         sh_bcd_d = digit_bcd;
         sh_dp_d  = dp_mask;
      end
   end

   // Next state: every slot opens in GUARD and switches to DRIVE once the guard window has elapsed.
   always_comb begin
      state_d = (presc_d >= GUARD_END) ? ST_DRIVE : ST_GUARD;
   end

   // Current digit glyph lookup from the shadow copy.
   always_comb begin
      cur_nib = sh_bcd_q[3:0];
      case (idx_q)
         2'd0: cur_nib = sh_bcd_q[3:0];
         2'd1: cur_nib = sh_bcd_q[7:4];
         2'd2: cur_nib = sh_bcd_q[11:8];
         2'd3: cur_nib = sh_bcd_q[15:12];
         default: cur_nib = sh_bcd_q[3:0];
      endcase
      cur_dp = sh_dp_q[idx_q];
      case (cur_nib)
         4'd0: glyph = 7'h40;
         4'd1: glyph = 7'h79;
         4'd2: glyph = 7'h24;
         4'd3: glyph = 7'h30;
         4'd4: glyph = 7'h19;
         4'd5: glyph = 7'h12;
         4'd6: glyph = 7'h02;
         4'd7: glyph = 7'h78;
         4'd8: glyph = 7'h00;
         4'd9: glyph = 7'h10;
         default: glyph = 7'h3F;
      endcase
   end

`ifdef SEG_LEADING_ZERO_BLANK_EN
   logic [3:0] lz_dark;

   // Leading-zero suppression: a digit goes dark only if it and every digit to its left are zero.
   always_comb begin
      lz_dark[3] = (sh_bcd_q[15:12] == 4'd0);
      lz_dark[2] = lz_dark[3] && (sh_bcd_q[11:8] == 4'd0);
      lz_dark[1] = lz_dark[2] && (sh_bcd_q[7:4] == 4'd0);
      lz_dark[0] = 1'b0;
      digit_dark = lz_dark[idx_q];
   end
`else
   // Every digit is always driven.
   always_comb begin
      digit_dark = 1'b0;
   end
`endif

   // Output decision: only one anode low, gated by DRIVE, blank, PWM and suppression.
   always_comb begin
      an_d  = 4'hF;
      seg_d = 8'hFF;
      if ((state_q == ST_DRIVE) && !blank && (brightness > pwm_q) &&
          !(digit_dark && !cur_dp)) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = {~cur_dp, (digit_dark ? 7'h7F : glyph)};
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         state_q  <= ST_GUARD;
         presc_q  <= '0;
         idx_q    <= 2'd0;
         tick_q   <= 1'b0;
         pwm_q    <= 4'd0;
         sh_bcd_q <= 16'h0000;
         sh_dp_q  <= 4'h0;
         first_q  <= 1'b1;
         an_q     <= 4'hF;
         seg_q    <= 8'hFF;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         tick_q   <= tick_d;
         pwm_q    <= pwm_d;
         sh_bcd_q <= sh_bcd_d;
         sh_dp_q  <= sh_dp_d;
         first_q  <= first_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign digit_idx  = idx_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic [15:0] bcd;
   logic [3:0]  dp;
   logic [3:0]  bright;
   logic        blank;
   logic [3:0]  an;
   logic [7:0]  seg;
   logic [1:0]  idx;
   logic        tick;

   int vectors    = 0;
   int miscompares = 0;
   int k          = 0;

   seg_scan_ctrl #(.REFRESH_DIV(8), .GUARD_CYC(2)) dut (
      .CLK100MHZ (clk),
      .CPU_RESETN(resetn),
      .digit_bcd (bcd),
      .dp_mask   (dp),
      .brightness(bright),
      .blank     (blank),
      .an        (an),
      .seg       (seg),
      .digit_idx (idx),
      .frame_tick(tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      k++;
   endtask

   task automatic goto(input int target);
      while (k < target) step();
   endtask

   task automatic chk_out(input string tag, input logic [3:0] e_an, input logic [7:0] e_seg);
      chk({tag, "_an"}, {4'h0, an}, {4'h0, e_an});
      chk({tag, "_seg"}, seg, e_seg);
   endtask

   initial begin
      resetn = 1'b0;
      bcd    = 16'h1234;
      dp     = 4'h0;
      bright = 4'd15;
      blank  = 1'b0;
      @(negedge clk);
      repeat (3) begin
         step();
         chk_out("rst", 4'hF, 8'hFF);
         chk("rst_idx", {6'd0, idx}, 8'd0);
         chk("rst_tick", {7'd0, tick}, 8'd0);
      end
      resetn = 1'b1;
      k = 0;

      goto(1);   chk_out("rel1", 4'hF, 8'hFF); chk("rel1_idx", {6'd0, idx}, 8'd0);
      goto(2);   chk_out("rel2", 4'hF, 8'hFF);
      goto(3);   chk_out("d0", 4'hE, 8'h99);   chk("d0_idx", {6'd0, idx}, 8'd0);
      goto(9);   chk_out("guard1", 4'hF, 8'hFF);
      goto(11);  chk_out("d1", 4'hD, 8'hB0);   chk("d1_idx", {6'd0, idx}, 8'd1);
      goto(16);  chk_out("pwm15", 4'hF, 8'hFF);
      goto(19);  chk_out("d2", 4'hB, 8'hA4);
      goto(27);  chk_out("d3", 4'h7, 8'hF9);   chk("d3_idx", {6'd0, idx}, 8'd3);
      goto(30);  chk("tick30", {7'd0, tick}, 8'd0);
      goto(31);  chk("tick31", {7'd0, tick}, 8'd1); chk("idx31", {6'd0, idx}, 8'd3);
      goto(32);  chk("tick32", {7'd0, tick}, 8'd0); chk("idx32", {6'd0, idx}, 8'd0);
      goto(63);  chk("tick63", {7'd0, tick}, 8'd1);

      goto(70);  bcd = 16'h5678;
      goto(75);  chk_out("old_d1", 4'hD, 8'hB0);
      goto(91);  chk_out("old_d3", 4'h7, 8'hF9);
      goto(99);  chk_out("new_d0", 4'hE, 8'h80);
      goto(107); chk_out("new_d1", 4'hD, 8'hF8);

      goto(112); bright = 4'd4;
      goto(116); chk_out("br4_on", 4'hB, 8'h82);
      goto(117); chk_out("br4_off", 4'hF, 8'hFF);
      goto(130); chk_out("guard2", 4'hF, 8'hFF);
      goto(131); chk_out("br4_d0", 4'hE, 8'h80);
      bright = 4'd0;
      goto(147); chk_out("br0", 4'hF, 8'hFF);
      bright = 4'd15;

      goto(148); blank = 1'b1;
      goto(150); chk_out("blank", 4'hF, 8'hFF); chk("blank_idx", {6'd0, idx}, 8'd2);
      goto(158); chk_out("blank_end", 4'hF, 8'hFF);
      blank = 1'b0;
      goto(159); chk_out("unblank", 4'h7, 8'h92);

      goto(170);
      resetn = 1'b0;
      bcd    = 16'h0070;
      dp     = 4'b0001;
      step();
      chk_out("midrst", 4'hF, 8'hFF);
      chk("midrst_idx", {6'd0, idx}, 8'd0);
      chk("midrst_tick", {7'd0, tick}, 8'd0);
      step();
      resetn = 1'b1;
      k = 0;

      goto(3);   chk_out("lz_d0", 4'hE, 8'h40);
      goto(11);  chk_out("lz_d1", 4'hD, 8'hF8);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      goto(19);  chk_out("lz_d2", 4'hF, 8'hFF);
      goto(27);  chk_out("lz_d3", 4'hF, 8'hFF);
`else
      goto(19);  chk_out("lz_d2", 4'hB, 8'hC0);
      goto(27);  chk_out("lz_d3", 4'h7, 8'hC0);
`endif
      goto(28);  bcd = 16'h00C0;
      goto(43);  chk_out("dash", 4'hD, 8'hBF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
